posit_rd_req_sched: RTL

- Schedules operand-fetch read requests from the posit FU onto the CCI-P c0 transmit channel.
- Buffers request indices in a small FIFO and converts each index to a cache-line address.
- Throttles issue on c0 almost-full and on an outstanding-request credit limit; tracks responses.
- Sits between the FU's mem_read request port and the host c0 Tx/Rx structs, next to the CSR decode.

---
 rtl/posit_sched_pkg.sv | 19 +
 rtl/posit_sched_fifo.sv | 53 +++++
 rtl/posit_rd_req_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/posit_sched_pkg.sv
// posit_sched_pkg
// Shared types and constants for the posit FU read-request scheduler.
//   t_sched_state : scheduler FSM state encoding
//   CL_BYTE_SHIFT : log2 of the cache-line size in bytes
//   t_line_addr   : cache-line address at the default width
package posit_sched_pkg;

  localparam int CL_BYTE_SHIFT = 6;
  localparam int LINE_ADDR_W   = 42;

  typedef logic [LINE_ADDR_W-1:0] t_line_addr;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } t_sched_state;

endpackage

// File: rtl/posit_sched_fifo.sv
// posit_sched_fifo
// Synchronous FIFO holding pending element indices.
//   clock, reset      : clock, async active-high reset (empties the FIFO)
//   push, wr_data     : write an entry (ignored when full unless popping too)
//   pop, rd_data      : read head entry (rd_data is the current head)
//   full, empty, count: occupancy status
module posit_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/posit_rd_req_sched.sv
// posit_rd_req_sched
// Schedules posit FU operand-fetch reads onto the CCI-P c0 Tx channel.
// Indices are queued, converted to line addresses (base + gran*idx/64) and
// issued one per cycle while c0 is not almost-full and credits remain.
//   cfg_*        : configuration load (IDLE only), cfg_reject otherwise
//   req_*        : FU request handshake, req_idx doubles as the response tag
//   flush        : stop accepting and drain; flush_done when drained
//   c0_almfull   : c0 back-pressure
//   rd_*         : registered c0 read request
//   rsp_valid    : c0 read response, decrements outstanding
//   outstanding, idle, err_unexpected_rsp : status
//
// state  | meaning
// IDLE   | unconfigured/drained, requests refused, cfg accepted
// ACTIVE | accepting requests, flush -> DRAIN
// DRAIN  | refusing requests, issuing remaining ones until idle
module posit_rd_req_sched
  import posit_sched_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_W          = 42
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [7:0]        cfg_granularity,
  output logic              cfg_reject,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_idx,
  input  logic              flush,
  output logic              flush_done,
  input  logic              c0_almfull,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_mdata,
  input  logic              rsp_valid,
  output logic [7:0]        outstanding,
  output logic              idle,
  output logic              err_unexpected_rsp
);

  localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  t_sched_state      state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        gran_q;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        head_idx;
  logic              push, pop, rsp_dec;
  logic              load_cfg, cfg_reject_d, flush_done_d;
  logic [15:0]       prod, line_off;

  posit_sched_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (req_idx),
    .pop     (pop),
    .rd_data (head_idx),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign req_ready = (state_q == ACTIVE) && !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = !fifo_empty && !c0_almfull && (outstanding < MAX_OUT);
  // A response with nothing in flight is flagged, never counted down.
  assign rsp_dec   = rsp_valid && (outstanding != 8'd0);
  assign idle      = (fifo_count == '0) && (outstanding == 8'd0) && !rd_valid;

  // Byte offset is truncated to 16 bits before conversion to lines.
  assign prod     = {8'b0, gran_q} * {8'b0, head_idx};
  assign line_off = prod >> CL_BYTE_SHIFT;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load_cfg     = 1'b0;
    cfg_reject_d = 1'b0;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) flush_done_d = 1'b1;
        if (cfg_valid) begin
          load_cfg = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        cfg_reject_d = cfg_valid;
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        cfg_reject_d = cfg_valid;
        if (idle) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q             <= '0;
      gran_q             <= '0;
      cfg_reject         <= 1'b0;
      flush_done         <= 1'b0;
      rd_valid           <= 1'b0;
      rd_addr            <= '0;
      rd_mdata           <= '0;
      outstanding        <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (load_cfg) begin
        base_q <= cfg_base_addr;
        gran_q <= cfg_granularity;
      end
      cfg_reject <= cfg_reject_d;
      flush_done <= flush_done_d;
      rd_valid   <= pop;
      if (pop) begin
        rd_addr  <= base_q + ADDR_W'(line_off);
        rd_mdata <= {8'b0, head_idx};
      end
      outstanding <= outstanding + 8'(pop) - 8'(rsp_dec);
      if (rsp_valid && (outstanding == 8'd0)) err_unexpected_rsp <= 1'b1;
    end
  end

endmodule
